// File: rtl/next_pc_unit.sv
// Next-PC selection for the 8-bit PC register: sequential, branch, jump, call, return,
// with a small return-address stack. Stack faults steer the PC to the 8'd255 halt sentinel.
module next_pc_unit #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] pc,
    input  logic       stall,
    input  logic       branch_taken,
    input  logic [7:0] branch_offset,
    input  logic       jump,
    input  logic       call,
    input  logic [7:0] target,
    input  logic       ret,
    output logic [7:0] pc_next,
    output logic [3:0] ras_depth,
    output logic       overflow,
    output logic       underflow
);

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);
    localparam logic [7:0] HALT_PC = 8'd255;

    // Storage is sized for the largest legal DEPTH; only the low DEPTH entries are used.
    logic [7:0] ras [8];

    logic [7:0] seq;
    logic [2:0] top_idx;
    logic       ras_full;
    logic       ras_empty;
    logic       do_push;
    logic       do_pop;
    logic       set_ovf;
    logic       set_udf;

    assign seq       = pc + 8'd1;
    assign top_idx   = ras_depth[2:0] - 3'd1;
    assign ras_full  = (ras_depth == DEPTH_C);
    assign ras_empty = (ras_depth == 4'd0);

    always_comb begin
        pc_next = seq;
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_ovf = 1'b0;
        set_udf = 1'b0;
        if (stall) begin
            pc_next = pc;
        end else if (ret) begin
            if (ras_empty) begin
                pc_next = HALT_PC;
                set_udf = 1'b1;
            end else begin
                pc_next = ras[top_idx];
                do_pop  = 1'b1;
            end
        end else if (call) begin
            if (ras_full) begin
                pc_next = HALT_PC;
                set_ovf = 1'b1;
            end else begin
                pc_next = target;
                do_push = 1'b1;
            end
        end else if (jump) begin
            pc_next = target;
        end else if (branch_taken) begin
            pc_next = seq + branch_offset;
        end
    end

    // Negedge matches the PC register's capture edge, so a pop right after a push sees the new entry.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ras_depth <= 4'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                ras[i] <= 8'd0;
            end
        end else begin
            if (do_push) begin
                ras[ras_depth[2:0]] <= seq;
                ras_depth           <= ras_depth + 4'd1;
            end else if (do_pop) begin
                ras_depth <= ras_depth - 4'd1;
            end
            if (set_ovf) begin
                overflow <= 1'b1;
            end
            if (set_udf) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Computes the next program-counter value for the 8-bit PC register and drives its `pcin` input each cycle. Selects among sequential increment, PC-relative branch, absolute jump, call and return, and keeps call return addresses in a small hardware return-address stack (RAS). Sits directly upstream of the PC register, consuming its `pcout` and the decode-stage control strobes. Stack faults steer the PC to the 8'd255 halt sentinel so the simulation terminates cleanly.

## Interface
- `DEPTH`, default 4: number of RAS entries; legal values 2–8.
- `clk` input, 1 bit: clock. State updates on the negedge, the same edge on which the PC register captures.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `pc` input, 8 bits: current PC, driven by the PC register's `pcout`.
- `stall` input, 1 bit: hold the PC and freeze the RAS.
- `branch_taken` input, 1 bit: PC-relative branch.
- `branch_offset` input, 8 bits: signed two's-complement offset, relative to `pc+1`.
- `jump` input, 1 bit: absolute jump.
- `call` input, 1 bit: absolute call.
- `target` input, 8 bits: absolute address for `jump` and `call`.
- `ret` input, 1 bit: return to the address on top of the RAS.
- `pc_next` output, 8 bits: combinational next PC, wired to the PC register's `pcin`.
- `ras_depth` output, 4 bits: registered count of valid RAS entries.
- `overflow` output, 1 bit: sticky; a call was attempted while the RAS was full.
- `underflow` output, 1 bit: sticky; a return was attempted while the RAS was empty.

## Operation
- Selection priority, highest first:
  1. `stall`
  2. `ret`
  3. `call`
  4. `jump`
  5. `branch_taken`
  6. sequential
- Lower-priority strobes asserted in the same cycle are ignored entirely, with no side effects.
- All PC arithmetic is 8-bit modulo 256. Define `seq = pc + 1`.
- **stall:** `pc_next = pc`. No RAS change, no flag change.
- **ret:**
  - RAS non-empty: `pc_next = RAS[top]`, and at the edge `ras_depth` decrements.
  - RAS empty: `pc_next = 8'd255`, and at the edge `underflow` sets. `ras_depth` stays 0.
- **call:**
  - RAS not full: `pc_next = target`. At the edge, `seq` is written to `RAS[ras_depth]` and `ras_depth` increments.
  - RAS full (`ras_depth == DEPTH`): `pc_next = 8'd255`, `overflow` sets, and no push occurs.
- **jump:** `pc_next = target`.
- **branch:** `pc_next = seq + branch_offset`, sign-extended, wrapping modulo 256.
- **sequential:** `pc_next = seq`. At pc = 8'd254 this yields 8'd255, the halt sentinel. Going past 255 is unreachable, because the PC register halts there.
- The RAS is a LIFO of `DEPTH` 8-bit entries indexed by `ras_depth`, with top = `ras_depth-1`. Entries at or above `ras_depth` are don't-care.
- Sticky flags clear only on reset.
- Computed results equal to 8'd255, whether from a branch, a jump, or a stored return address, are passed through unmodified. Halting is the PC register's job.

## Timing
- `pc_next` is purely combinational from `pc`, the strobes, `target`, `branch_offset` and the RAS top. No latency: the value presented before a negedge is what the PC register captures at that edge.
- RAS contents, `ras_depth`, `overflow` and `underflow` update on the negedge of `clk`. Their new values are visible from that edge onward.
- Back-to-back call followed by ret on consecutive cycles must return `seq` of the call. The pop reads the entry written at the previous edge.
- Reset (`reset_n` low, asynchronous, any time, including mid-call):
  - `ras_depth = 0`, `overflow = 0`, `underflow = 0`.
  - All RAS entries are 8'd0.
  - `pc_next` is then `pc+1` unless a strobe is asserted.
- While `reset_n` is low, no push or pop occurs, regardless of the strobes.
- Strobes are sampled around the negedge and must be stable from the preceding posedge. No handshake is involved; each strobe acts for exactly one cycle.

## Test plan
- **Reset and sequential:** pulse `reset_n` low, pc=8'd10, no strobes -> `pc_next=11`, `ras_depth=0`, both flags 0. Pulse reset mid-stream with `ras_depth=3` -> `ras_depth=0` immediately, asynchronously.
- **Branch arithmetic:**
  - pc=8'd20, offset=8'hFC (−4) -> `pc_next=17`.
  - pc=8'd250, offset=8'd10 -> `pc_next=5` (wrap).
  - pc=8'd254, no strobes -> `pc_next=255`.
- **Call/return nesting:** call target 40 at pc=5, then call target 80 at pc=41, then ret, then ret -> `pc_next` sequence 40, 80, 42, 6; `ras_depth` sequence 1, 2, 1, 0.
- **Overflow and underflow:**
  - With DEPTH=4, issue 5 calls -> 5th `pc_next=255`, `overflow=1`, `ras_depth=4`.
  - After reset, ret -> `pc_next=255`, `underflow=1`, `ras_depth=0`.
- **Priority and stall:**
  - `ret`+`call`+`jump` together with a non-empty RAS -> only the pop occurs, `pc_next` = top entry.
  - `stall`+`call` -> `pc_next=pc`, `ras_depth` unchanged.
  - `jump` target 8'd255 -> `pc_next=255`.
- **Integration:** connected to the PC register, run a program ending in sequential execution to 255 -> simulation ends via `$finish` with `ras_depth` at its expected value.
